// File: rtl/jacobi_pkg.sv
//==============================================================================
// Module      : jacobi_pkg
// Description : Shared types and constants for the Jacobi datapath matrix RAM
//               controller.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package jacobi_pkg;

    // Controller phases: waiting, filling the RAM, streaming it back out
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2
    } mctrl_state_t;

    // Default matrix element width
    localparam int c_DATA_WIDTH = 20;

endpackage

`default_nettype wire

// File: rtl/matrix_addr_gen.sv
//==============================================================================
// Module      : matrix_addr_gen
// Description : Multiplier-free N x N element address walker. Row-major walk
//               steps by 1; column-major walk steps by N and restarts at the
//               next column on row wrap. o_last flags the final element.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module matrix_addr_gen #(
    parameter int N          = 4,
    parameter int ADDR_WIDTH = 7
)(
    input  wire logic                  clk,
    input  wire logic                  rst_n,
    input  wire logic                  i_clr,
    input  wire logic                  i_step,
    input  wire logic                  i_transpose,
    output logic      [ADDR_WIDTH-1:0] o_addr,
    output logic                       o_last
);

    localparam int IDX_W = $clog2(N*N + 1);
    localparam int CW    = $clog2(N + 1);
    localparam logic [IDX_W-1:0]      c_LAST_IDX = IDX_W'(N*N - 1);
    localparam logic [CW-1:0]         c_ROW_END  = CW'(N - 1);
    localparam logic [ADDR_WIDTH-1:0] c_STRIDE   = ADDR_WIDTH'(N);

    logic [ADDR_WIDTH-1:0] r_addr;
    logic [IDX_W-1:0]      r_idx;
    logic [CW-1:0]         r_row;   // position inside the current column
    logic [CW-1:0]         r_col;   // column currently being walked

    // Advance the element index and address on every step, restart on clear
    always_ff @(posedge clk) begin
        if (!rst_n || i_clr) begin
            r_addr <= '0;
            r_idx  <= '0;
            r_row  <= '0;
            r_col  <= '0;
        end else if (i_step) begin
            r_idx <= r_idx + 1'b1;
            if (i_transpose) begin
                if (r_row == c_ROW_END) begin
                    r_row  <= '0;
                    r_col  <= r_col + 1'b1;
                    r_addr <= ADDR_WIDTH'(r_col) + 1'b1;
                end else begin
                    r_row  <= r_row + 1'b1;
                    r_addr <= r_addr + c_STRIDE;
                end
            end else begin
                r_addr <= r_addr + 1'b1;
            end
        end
    end

    assign o_addr = r_addr;
    assign o_last = (r_idx == c_LAST_IDX);

endmodule

`default_nettype wire

// File: rtl/matrix_ram_ctrl.sv
//==============================================================================
// Module      : matrix_ram_ctrl
// Description : Loads one N x N matrix into a dual-port RAM through port A
//               and streams it back out through port B (optionally
//               transposed). Port B has 2-cycle read latency; the read pipe
//               is frozen through the RAM enable under backpressure.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module matrix_ram_ctrl
    import jacobi_pkg::*;
#(
    parameter int N          = 4,
    parameter int DATA_WIDTH = c_DATA_WIDTH,
    parameter int ADDR_WIDTH = 7,
    parameter int MEM_SIZE   = 128,
    parameter bit TRANSPOSE  = 1'b1
)(
    input  wire logic                  clk,
    input  wire logic                  rst_n,
    input  wire logic                  start,
    input  wire logic [DATA_WIDTH-1:0] in_data,
    input  wire logic                  in_valid,
    output logic                       in_ready,
    output logic      [DATA_WIDTH-1:0] out_data,
    output logic                       out_valid,
    input  wire logic                  out_ready,
    output logic                       out_last,
    output logic                       busy,
    output logic                       done,
    output logic                       ram_en_a,
    output logic                       ram_we_a,
    output logic      [ADDR_WIDTH-1:0] ram_addr_a,
    output logic      [DATA_WIDTH-1:0] ram_din_a,
    output logic                       ram_en_b,
    output logic                       ram_we_b,
    output logic      [ADDR_WIDTH-1:0] ram_addr_b,
    input  wire logic [DATA_WIDTH-1:0] ram_dout_b
);

    generate
        if (N < 1 || N*N > MEM_SIZE) begin : g_size_check
            $error("matrix_ram_ctrl: N*N=%0d does not fit MEM_SIZE=%0d", N*N, MEM_SIZE);
        end
    endgenerate

    mctrl_state_t          r_state;
    logic                  r_rd_done;   // every element of the readout issued
    logic                  r_s1_v;
    logic                  r_s2_v;
    logic                  r_s1_last;
    logic                  r_s2_last;

    logic                  w_wr;
    logic                  w_en_b;
    logic                  w_issue;
    logic                  w_accept;
    logic                  w_last_a;
    logic                  w_last_b;
    logic [ADDR_WIDTH-1:0] w_addr_a;
    logic [ADDR_WIDTH-1:0] w_addr_b;

    assign w_wr     = in_valid && (r_state == LOAD);
    // The read pipe only moves when its output slot is empty or being taken
    assign w_en_b   = !r_s2_v || out_ready;
    assign w_issue  = (r_state == DRAIN) && w_en_b && !r_rd_done;
    assign w_accept = r_s2_v && out_ready;

    matrix_addr_gen #(
        .N          (N),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_addr_a (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_clr       (r_state != LOAD),
        .i_step      (w_wr),
        .i_transpose (1'b0),
        .o_addr      (w_addr_a),
        .o_last      (w_last_a)
    );

    matrix_addr_gen #(
        .N          (N),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_addr_b (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_clr       (r_state != DRAIN),
        .i_step      (w_issue),
        .i_transpose (TRANSPOSE),
        .o_addr      (w_addr_b),
        .o_last      (w_last_b)
    );

    // Phase sequencing: start -> fill -> readout -> back to idle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            case (r_state)
                IDLE:    if (start)                  r_state <= LOAD;
                LOAD:    if (w_wr && w_last_a)       r_state <= DRAIN;
                DRAIN:   if (w_accept && r_s2_last)  r_state <= IDLE;
                default:                             r_state <= IDLE;
            endcase
        end
    end

    // Stop issuing reads once the final element address has gone out
    always_ff @(posedge clk) begin
        if (!rst_n || r_state != DRAIN) begin
            r_rd_done <= 1'b0;
        end else if (w_issue && w_last_b) begin
            r_rd_done <= 1'b1;
        end
    end

    // Valid/last flags travel alongside the 2-stage RAM read pipe
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_v    <= 1'b0;
            r_s2_v    <= 1'b0;
            r_s1_last <= 1'b0;
            r_s2_last <= 1'b0;
        end else if (w_en_b) begin
            r_s1_v    <= w_issue;
            r_s1_last <= w_issue && w_last_b;
            r_s2_v    <= r_s1_v;
            r_s2_last <= r_s1_last;
        end
    end

    assign in_ready   = (r_state == LOAD);
    assign busy       = (r_state != IDLE);
    assign out_valid  = r_s2_v;
    assign out_last   = r_s2_last;
    assign out_data   = ram_dout_b;
    assign done       = w_accept && r_s2_last;

    assign ram_en_a   = w_wr;
    assign ram_we_a   = w_wr;
    assign ram_addr_a = w_addr_a;
    assign ram_din_a  = in_data;

    assign ram_en_b   = w_en_b;
    assign ram_we_b   = 1'b0;
    assign ram_addr_b = w_addr_b;

endmodule

`default_nettype wire

// File: tb/tb_matrix_ram_ctrl.sv
//==============================================================================
// Module      : tb_matrix_ram_ctrl
// Description : Self-checking bench for matrix_ram_ctrl. Instance 0 reads
//               transposed, instance 1 reads row-major; each has its own
//               behavioural dual-port RAM with 2-cycle port-B latency.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_matrix_ram_ctrl;

    localparam int NN = 4;
    localparam int DW = 20;
    localparam int AW = 7;

    logic          clk = 1'b0;
    logic          rst_n      [2];
    logic          start      [2];
    logic [DW-1:0] in_data    [2];
    logic          in_valid   [2];
    logic          in_ready   [2];
    logic [DW-1:0] out_data   [2];
    logic          out_valid  [2];
    logic          out_ready  [2];
    logic          out_last   [2];
    logic          busy       [2];
    logic          done       [2];
    logic          ram_en_a   [2];
    logic          ram_we_a   [2];
    logic [AW-1:0] ram_addr_a [2];
    logic [DW-1:0] ram_din_a  [2];
    logic          ram_en_b   [2];
    logic          ram_we_b   [2];
    logic [AW-1:0] ram_addr_b [2];
    logic [DW-1:0] ram_dout_b [2];

    logic [DW-1:0] mem  [2][128];
    logic [DW-1:0] q1   [2];
    logic [DW-1:0] q2   [2];
    logic [DW-1:0] refm [2][NN*NN];   // matrix as loaded, row-major

    int n_err = 0;
    int n_chk = 0;

    always #5 clk = ~clk;

    matrix_ram_ctrl #(.N(NN), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_SIZE(128), .TRANSPOSE(1'b1)) u_dut_t (
        .clk(clk), .rst_n(rst_n[0]), .start(start[0]), .in_data(in_data[0]), .in_valid(in_valid[0]),
        .in_ready(in_ready[0]), .out_data(out_data[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_last(out_last[0]), .busy(busy[0]), .done(done[0]), .ram_en_a(ram_en_a[0]), .ram_we_a(ram_we_a[0]),
        .ram_addr_a(ram_addr_a[0]), .ram_din_a(ram_din_a[0]), .ram_en_b(ram_en_b[0]), .ram_we_b(ram_we_b[0]),
        .ram_addr_b(ram_addr_b[0]), .ram_dout_b(ram_dout_b[0]));

    matrix_ram_ctrl #(.N(NN), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_SIZE(128), .TRANSPOSE(1'b0)) u_dut_r (
        .clk(clk), .rst_n(rst_n[1]), .start(start[1]), .in_data(in_data[1]), .in_valid(in_valid[1]),
        .in_ready(in_ready[1]), .out_data(out_data[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_last(out_last[1]), .busy(busy[1]), .done(done[1]), .ram_en_a(ram_en_a[1]), .ram_we_a(ram_we_a[1]),
        .ram_addr_a(ram_addr_a[1]), .ram_din_a(ram_din_a[1]), .ram_en_b(ram_en_b[1]), .ram_we_b(ram_we_b[1]),
        .ram_addr_b(ram_addr_b[1]), .ram_dout_b(ram_dout_b[1]));

    // Behavioural dual-port RAM: write on port A, 2-stage enabled read on port B
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (ram_en_a[d] && ram_we_a[d]) mem[d][ram_addr_a[d]] <= ram_din_a[d];
            if (ram_en_b[d]) begin
                q1[d] <= mem[d][ram_addr_b[d]];
                q2[d] <= q1[d];
            end
        end
    end

    assign ram_dout_b[0] = q2[0];
    assign ram_dout_b[1] = q2[1];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected k-th readout element from the matrix semantics
    function automatic logic [DW-1:0] expv(input int d, input int k);
        if (d == 0) return refm[d][(k % NN) * NN + k / NN];   // column-major
        return refm[d][k];                                    // row-major
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int d, input int base, input bit rnd, input bit poke);
        int  i   = 0;
        int  cyc = 0;
        logic v;
        start[d] = 1'b1;
        next_cycle();
        start[d] = 1'b0;
        while (i < NN*NN && cyc < 200) begin
            v           = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
            in_valid[d] = v;
            in_data[d]  = rnd ? DW'($urandom) : DW'(base + i);
            if (poke && i == 5) start[d] = 1'b1;
            @(negedge clk);
            chk("ld_in_ready", in_ready[d], 1);
            chk("ld_we_a", ram_we_a[d], v);
            chk("ld_en_a", ram_en_a[d], v);
            if (v) begin
                chk("ld_addr_a", ram_addr_a[d], i);
                chk("ld_din_a", ram_din_a[d], in_data[d]);
                refm[d][i] = in_data[d];
                i++;
            end
            next_cycle();
            start[d] = 1'b0;
            cyc++;
        end
        in_valid[d] = 1'b0;
        chk("ld_beats", i, NN*NN);
    endtask

    // mode 0: always ready, 1: random ready, 2: hold off on the beat carrying 6
    task automatic drain(input int d, input int mode, input int rst_at, input bit chk_lat, input bit poke);
        int   k     = 0;
        int   cyc   = 0;
        int   first = -1;
        int   stall = 0;
        logic rdy;
        while (k < NN*NN && cyc < 300) begin
            rdy = 1'b1;
            if (mode == 1) rdy = ($urandom_range(0, 3) != 0);
            if (mode == 2 && out_valid[d] && out_data[d] == 6 && stall < 5) begin
                rdy = 1'b0;
                stall++;
            end
            out_ready[d] = rdy;
            if (poke && cyc == 4) start[d] = 1'b1;
            @(negedge clk);
            if (out_valid[d] && first < 0) first = cyc;
            if (mode == 2 && !rdy) begin
                chk("stall_data", out_data[d], 6);
                chk("stall_valid", out_valid[d], 1);
                chk("stall_en_b", ram_en_b[d], 0);
            end
            if (out_valid[d] && rdy) begin
                chk("rd_data", out_data[d], expv(d, k));
                chk("rd_last", out_last[d], (k == NN*NN-1));
                chk("rd_done", done[d], (k == NN*NN-1));
                k++;
            end else begin
                chk("rd_done_idle", done[d], 0);
            end
            next_cycle();
            start[d] = 1'b0;
            cyc++;
            if (rst_at >= 0 && k == rst_at) begin
                rst_n[d] = 1'b0;
                next_cycle();
                rst_n[d] = 1'b1;
                chk("rst_out_valid", out_valid[d], 0);
                chk("rst_busy", busy[d], 0);
                chk("rst_in_ready", in_ready[d], 0);
                out_ready[d] = 1'b0;
                return;
            end
        end
        chk("rd_beats", k, NN*NN);
        if (chk_lat) chk("first_valid_lat", first, 2);
        out_ready[d] = 1'b1;
        @(negedge clk);
        chk("end_busy", busy[d], 0);
        chk("end_out_valid", out_valid[d], 0);
        next_cycle();
        out_ready[d] = 1'b0;
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst_n[d] = 1'b0; start[d] = 1'b0; in_data[d] = '0;
            in_valid[d] = 1'b0; out_ready[d] = 1'b0;
        end
        next_cycle();
        next_cycle();
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("rst_in_ready", in_ready[d], 0);
            chk("rst_out_valid", out_valid[d], 0);
            chk("rst_out_last", out_last[d], 0);
            chk("rst_busy", busy[d], 0);
            chk("rst_done", done[d], 0);
            chk("rst_we_a", ram_we_a[d], 0);
            chk("rst_we_b", ram_we_b[d], 0);
        end
        next_cycle();
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;
        next_cycle();

        // in_valid while idle must not reach the RAM
        in_valid[0] = 1'b1;
        in_data[0]  = 20'h5;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("idle_we_a", ram_we_a[0], 0);
            chk("idle_in_ready", in_ready[0], 0);
            chk("idle_busy", busy[0], 0);
            next_cycle();
        end
        in_valid[0] = 1'b0;

        // Transposed and row-major readout of 0..15, with latency
        load(0, 0, 1'b0, 1'b0);
        drain(0, 0, -1, 1'b1, 1'b0);
        load(1, 0, 1'b0, 1'b0);
        drain(1, 0, -1, 1'b1, 1'b0);

        // Backpressure on the beat carrying 6
        load(1, 0, 1'b0, 1'b0);
        drain(1, 2, -1, 1'b0, 1'b0);

        // Random data, input gaps, output backpressure, stray start pulses
        load(0, 0, 1'b1, 1'b1);
        drain(0, 1, -1, 1'b0, 1'b1);
        load(1, 0, 1'b1, 1'b1);
        drain(1, 1, -1, 1'b0, 1'b1);

        // Reset in the middle of a readout, then a fresh load of 100..115
        load(0, 0, 1'b0, 1'b0);
        drain(0, 0, 9, 1'b0, 1'b0);
        load(0, 100, 1'b0, 1'b0);
        drain(0, 0, -1, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
